fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Program-counter and fetch sequencer that drives InstAddress of the instruction ROM (A-bit address, W-bit instruction words).
- Runs a start/run/halt state machine, selects the next PC (sequential, absolute branch, relative branch, stall, halt), and counts executed cycles.
- Upstream of InstROM; consumes control from the decode/branch logic downstream of InstROM.

Parameters:
A, 10, PC / instruction address width
OW, 8, signed relative branch offset width (OW <= A)
CW, 16, cycle counter width

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  level; begin (or restart) program at address 0
Halt  input  1  decoded halt instruction at current PC
Stall  input  1  hold PC this cycle
BrAbs  input  1  absolute branch taken this cycle
BrRel  input  1  relative branch taken this cycle
Target  input  A  absolute branch target (from LUT)
Offset  input  OW  signed relative offset, applied to the current PC
InstAddress  output  A  current PC, feeds InstROM
Running  output  1  high in RUN
Done  output  1  high in HALTED
CycleCount  output  CW  cycles spent in RUN

Behaviour:
- One clock (Clk); Reset is synchronous and active-high.
- States: IDLE, RUN, HALTED. All outputs are registered state or decoded directly from state; the block adds no combinational path from inputs to outputs.
- Reset (priority over everything, including mid-run): state=IDLE, InstAddress=0, Running=0, Done=0, CycleCount=0.
- IDLE:
  - Start=0: hold state and PC.
  - Start=1: next state RUN, PC=0, CycleCount=0.
- RUN, Start=1 (restart): next PC=0, CycleCount=0, stay RUN. Overrides all other inputs.
- RUN, Start=0, next PC selected in strict priority:
  - Halt: PC holds, next state HALTED.
  - Stall: PC holds.
  - BrAbs: PC=Target.
  - BrRel: PC = PC + sign-extended Offset, mod 2^A.
  - Otherwise: PC = PC + 1, mod 2^A; 2^A-1 wraps to 0.
- BrAbs and BrRel together: BrAbs wins. Halt with any branch: Halt wins.
- CycleCount:
  - Increments by 1 on every clock edge where the state is RUN before the edge and Start=0, including stall and halt cycles.
  - Saturates at 2^CW-1 (no wrap).
  - Frozen in IDLE and HALTED.
- HALTED:
  - PC, CycleCount and Done hold; Halt, Stall and branch inputs are ignored.
  - Start=1: next state RUN, PC=0, CycleCount=0, Done=0.
- Running/Done are updated on the same edge as the state change. Latency from Start high to Running=1 and InstAddress=0 is 1 cycle.
- InstAddress is the PC register; ROM data for that address is valid combinationally in the same cycle.

Test Plan:
- Reset, then Start pulse at cycle 2, no branches for 5 cycles -> InstAddress sequence 0,1,2,3,4,5; Running=1; CycleCount=5.
- In RUN at PC=20: BrRel with Offset=-4 (8'hFC) -> PC=16. Next cycle BrAbs with Target=300 and BrRel both asserted -> PC=300 (abs wins).
- PC at 1023 with no branch -> PC=0. At PC=2: BrRel, Offset=-5 -> PC=1021.
- At PC=7: Stall for 3 cycles, then Halt -> PC stays 7; Done=1, Running=0; CycleCount grows by 4 and then freezes; later branch inputs do not change PC.
- In HALTED, Start=1 -> next cycle PC=0, Done=0, Running=1, CycleCount=0. Reset asserted mid-RUN at PC=50 -> next cycle IDLE, PC=0, all outputs 0.
- CW overridden to 4: run 20 cycles -> CycleCount saturates at 15.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencer for the instruction ROM.
// Runs an IDLE/RUN/HALTED machine, picks the next PC and counts cycles spent in RUN.
module fetch_sequencer #(
    parameter int A  = 10,
    parameter int OW = 8,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Halt,
    input  logic          Stall,
    input  logic          BrAbs,
    input  logic          BrRel,
    input  logic [A-1:0]  Target,
    input  logic [OW-1:0] Offset,
    output logic [A-1:0]  InstAddress,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [CW-1:0] COUNT_MAX = '1;

    state_t        state;
    state_t        state_next;
    logic [A-1:0]  pc;
    logic [A-1:0]  pc_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [A-1:0]  offset_ext;

    // Sign-extend the relative offset so the add wraps modulo 2^A.
    assign offset_ext = A'($signed(Offset));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_next = state;
        pc_next    = pc;
        count_next = count;

        unique case (state)
            IDLE: begin
                if (Start) begin
                    state_next = RUN;
                    pc_next    = '0;
                    count_next = '0;
                end
            end

            RUN: begin
                if (Start) begin
                    pc_next    = '0;
                    count_next = '0;
                end else begin
                    if (count != COUNT_MAX) begin
                        count_next = count + CW'(1);
                    end
                    if (Halt) begin
                        state_next = HALTED;
                    end else if (Stall) begin
                        pc_next = pc;
                    end else if (BrAbs) begin
                        pc_next = Target;
                    end else if (BrRel) begin
                        pc_next = pc + offset_ext;
                    end else begin
                        pc_next = pc + A'(1);
                    end
                end
            end

            HALTED: begin
                if (Start) begin
                    state_next = RUN;
                    pc_next    = '0;
                    count_next = '0;
                end
            end

            default: begin
                state_next = IDLE;
                pc_next    = '0;
                count_next = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            pc    <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            count <= count_next;
        end
    end

    // Outputs come straight from registers, so there is no input-to-output path.
    assign InstAddress = pc;
    assign CycleCount  = count;
    assign Running     = (state == RUN);
    assign Done        = (state == HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random traffic
// compared against a behavioural model; a CW=4 copy exercises counter saturation.
module tb_fetch_sequencer;

    localparam int A  = 10;
    localparam int OW = 8;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic          Halt;
    logic          Stall;
    logic          BrAbs;
    logic          BrRel;
    logic [A-1:0]  Target;
    logic [OW-1:0] Offset;
    logic [A-1:0]  InstAddress;
    logic          Running;
    logic          Done;
    logic [15:0]   CycleCount;
    logic [A-1:0]  InstAddress4;
    logic          Running4;
    logic          Done4;
    logic [3:0]    CycleCount4;

    int total = 0;
    int bad   = 0;

    // Behavioural model: running/done flags, PC and counters as plain integers.
    bit m_run;
    bit m_done;
    int m_pc;
    int m_cnt;
    int m_cnt4;

    fetch_sequencer #(.A(A), .OW(OW), .CW(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
        .BrAbs(BrAbs), .BrRel(BrRel), .Target(Target), .Offset(Offset),
        .InstAddress(InstAddress), .Running(Running), .Done(Done), .CycleCount(CycleCount)
    );

    fetch_sequencer #(.A(A), .OW(OW), .CW(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
        .BrAbs(BrAbs), .BrRel(BrRel), .Target(Target), .Offset(Offset),
        .InstAddress(InstAddress4), .Running(Running4), .Done(Done4), .CycleCount(CycleCount4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one cycle of inputs, clock it, advance the model, and settle 1 time unit past the edge.
    task automatic step(input logic rst, input logic st, input logic hl, input logic sl,
                        input logic ba, input logic br, input logic [A-1:0] tg,
                        input logic [OW-1:0] of);
        Reset  = rst;
        Start  = st;
        Halt   = hl;
        Stall  = sl;
        BrAbs  = ba;
        BrRel  = br;
        Target = tg;
        Offset = of;
        @(posedge Clk);
        if (rst) begin
            m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0; m_cnt4 = 0;
        end else if (st) begin
            m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0; m_cnt4 = 0;
        end else if (m_run) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
            if (hl) begin
                m_run = 0; m_done = 1;
            end else if (sl) begin
                m_pc = m_pc;
            end else if (ba) begin
                m_pc = int'(tg);
            end else if (br) begin
                m_pc = (m_pc + int'($signed(of)) + 1024) % 1024;
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
        #1;
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, '0, '0);
        step(1, 0, 0, 0, 0, 0, '0, '0);
        total++;
        if (InstAddress !== 10'd0 || Running !== 1'b0 || Done !== 1'b0 || CycleCount !== 16'd0) begin
            bad++;
            $display("FAIL reset: pc=%0d run=%b done=%b cnt=%0d, want 0/0/0/0",
                     InstAddress, Running, Done, CycleCount);
        end
    endtask

    task automatic test_sequential();
        idle_step();
        total++;
        if (InstAddress !== 10'd0 || Running !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: pc=%0d run=%b, want 0/0", InstAddress, Running);
        end
        step(0, 1, 0, 0, 0, 0, '0, '0);
        total++;
        if (InstAddress !== 10'd0 || Running !== 1'b1 || CycleCount !== 16'd0) begin
            bad++;
            $display("FAIL start: pc=%0d run=%b cnt=%0d, want 0/1/0", InstAddress, Running, CycleCount);
        end
        for (int i = 1; i <= 5; i++) begin
            idle_step();
            total++;
            if (InstAddress !== A'(i) || CycleCount !== 16'(i) || Running !== 1'b1) begin
                bad++;
                $display("FAIL seq_%0d: pc=%0d cnt=%0d run=%b, want %0d/%0d/1",
                         i, InstAddress, CycleCount, Running, i, i);
            end
        end
    endtask

    task automatic test_branches();
        step(0, 0, 0, 0, 1, 0, 10'd20, '0);
        step(0, 0, 0, 0, 0, 1, '0, 8'hFC);
        total++;
        if (InstAddress !== 10'd16) begin
            bad++;
            $display("FAIL rel_neg: pc=%0d, want 16", InstAddress);
        end
        step(0, 0, 0, 0, 1, 1, 10'd300, 8'h05);
        total++;
        if (InstAddress !== 10'd300) begin
            bad++;
            $display("FAIL abs_wins: pc=%0d, want 300", InstAddress);
        end
    endtask

    task automatic test_wrap();
        step(0, 0, 0, 0, 1, 0, 10'd1023, '0);
        idle_step();
        total++;
        if (InstAddress !== 10'd0) begin
            bad++;
            $display("FAIL wrap_inc: pc=%0d, want 0", InstAddress);
        end
        step(0, 0, 0, 0, 1, 0, 10'd2, '0);
        step(0, 0, 0, 0, 0, 1, '0, 8'hFB);
        total++;
        if (InstAddress !== 10'd1021) begin
            bad++;
            $display("FAIL wrap_rel: pc=%0d, want 1021", InstAddress);
        end
    endtask

    task automatic test_stall_halt();
        int c0;
        step(0, 0, 0, 0, 1, 0, 10'd7, '0);
        c0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 1, 1, 10'd99, 8'h10);
            total++;
            if (InstAddress !== 10'd7) begin
                bad++;
                $display("FAIL stall_%0d: pc=%0d, want 7", i, InstAddress);
            end
        end
        step(0, 0, 1, 0, 1, 0, 10'd55, '0);
        total++;
        if (InstAddress !== 10'd7 || Done !== 1'b1 || Running !== 1'b0 || CycleCount !== 16'(c0 + 4)) begin
            bad++;
            $display("FAIL halt: pc=%0d done=%b run=%b cnt=%0d, want 7/1/0/%0d",
                     InstAddress, Done, Running, CycleCount, c0 + 4);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1'($urandom), 1'($urandom), 1, 1, 10'd400, 8'h33);
            total++;
            if (InstAddress !== 10'd7 || Done !== 1'b1 || CycleCount !== 16'(c0 + 4)) begin
                bad++;
                $display("FAIL halted_hold_%0d: pc=%0d done=%b cnt=%0d, want 7/1/%0d",
                         i, InstAddress, Done, CycleCount, c0 + 4);
            end
        end
    endtask

    task automatic test_restart();
        step(0, 1, 0, 0, 0, 0, '0, '0);
        total++;
        if (InstAddress !== 10'd0 || Done !== 1'b0 || Running !== 1'b1 || CycleCount !== 16'd0) begin
            bad++;
            $display("FAIL restart_halted: pc=%0d done=%b run=%b cnt=%0d, want 0/0/1/0",
                     InstAddress, Done, Running, CycleCount);
        end
        step(0, 0, 0, 0, 1, 0, 10'd50, '0);
        step(1, 0, 0, 0, 0, 0, '0, '0);
        total++;
        if (InstAddress !== 10'd0 || Running !== 1'b0 || Done !== 1'b0 || CycleCount !== 16'd0) begin
            bad++;
            $display("FAIL reset_midrun: pc=%0d run=%b done=%b cnt=%0d, want 0/0/0/0",
                     InstAddress, Running, Done, CycleCount);
        end
        step(0, 0, 0, 0, 1, 0, 10'd100, '0);
        total++;
        if (InstAddress !== 10'd0 || Running !== 1'b0) begin
            bad++;
            $display("FAIL idle_ignores_branch: pc=%0d run=%b, want 0/0", InstAddress, Running);
        end
    endtask

    task automatic test_saturation();
        step(0, 1, 0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 20; i++) idle_step();
        total++;
        if (CycleCount4 !== 4'd15 || CycleCount !== 16'd20 || InstAddress !== 10'd20) begin
            bad++;
            $display("FAIL saturate: cnt4=%0d cnt=%0d pc=%0d, want 15/20/20",
                     CycleCount4, CycleCount, InstAddress);
        end
        step(0, 1, 1, 1, 1, 1, 10'd9, 8'h01);
        total++;
        if (InstAddress !== 10'd0 || CycleCount !== 16'd0 || CycleCount4 !== 4'd0 || Running !== 1'b1) begin
            bad++;
            $display("FAIL restart_run: pc=%0d cnt=%0d cnt4=%0d run=%b, want 0/0/0/1",
                     InstAddress, CycleCount, CycleCount4, Running);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(63) == 0), ($urandom_range(15) == 0), ($urandom_range(15) == 0),
                 ($urandom_range(4) == 0), ($urandom_range(5) == 0), ($urandom_range(5) == 0),
                 A'($urandom), OW'($urandom));
            total++;
            if (InstAddress !== A'(m_pc) || Running !== m_run || Done !== m_done ||
                CycleCount !== 16'(m_cnt) || CycleCount4 !== 4'(m_cnt4) || InstAddress4 !== A'(m_pc) ||
                Running4 !== m_run || Done4 !== m_done) begin
                bad++;
                $display("FAIL random_%0d: pc=%0d run=%b done=%b cnt=%0d cnt4=%0d, want %0d/%b/%b/%0d/%0d",
                         i, InstAddress, Running, Done, CycleCount, CycleCount4,
                         m_pc, m_run, m_done, m_cnt, m_cnt4);
            end
        end
    endtask

    initial begin
        Reset = 1; Start = 0; Halt = 0; Stall = 0; BrAbs = 0; BrRel = 0; Target = '0; Offset = '0;
        m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0; m_cnt4 = 0;
        test_reset();
        test_sequential();
        test_branches();
        test_wrap();
        test_stall_halt();
        test_restart();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
